// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
// Define SERIAL_TX_PARITY_EN to insert the even-parity bit before the stop bit.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [CCW-1:0]    cyc_q, cyc_d;
  logic              sdo_q, sdo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cyc_q == CCW'(CLKS_PER_BIT - 1));

  // sdo is registered, so each state loads the next bit's value on its final cycle
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE && !bit_end) begin
      cyc_d = cyc_q + CCW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d = S_START;
          shift_d = din;
          bit_d   = '0;
          cyc_d   = '0;
          sdo_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          sdo_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == BCW'(DATA_W - 1)) begin
            bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
            sdo_d   = par_q;
`else
            state_d = S_STOP;
            sdo_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BCW'(1);
            sdo_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cyc_d   = '0;
          sdo_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sdo_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      sdo_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign din_ready = (state_q == S_IDLE) && !rst;
  assign sdo       = sdo_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
